// File: rtl/serial_in_port_if.sv
// Serial input port bus bundle.
//
// Groups the serial line, its bit strobe, the consumer pop request and the
// FIFO status/data outputs of serial_in_port into one interface.
//   master : the surrounding logic (drives sin, sin_stb, ack)
//   slave  : serial_in_port itself (drives data_out, valid, full,
//            frame_err, overrun)
//
// Handshake: sin is meaningful only in a cycle with sin_stb=1. data_out is
// the FIFO head and is meaningful while valid=1. ack in a cycle where
// valid=1 pops the head at that clock edge; ack with valid=0 is ignored.
interface serial_in_port_if;
  logic       sin;
  logic       sin_stb;
  logic       ack;
  logic [7:0] data_out;
  logic       valid;
  logic       full;
  logic       frame_err;
  logic       overrun;

  modport master (
    output sin, sin_stb, ack,
    input  data_out, valid, full, frame_err, overrun
  );

  modport slave (
    input  sin, sin_stb, ack,
    output data_out, valid, full, frame_err, overrun
  );
endinterface

// File: rtl/serial_in_port.sv
// Serial input port: strobed serial receiver feeding a small byte FIFO.
//
// Frame: start bit 0, 8 data bits LSB first, optional parity bit, stop
// bit 1; exactly one bit is taken per sin_stb. A good frame is pushed into
// the FIFO at the edge that samples its stop bit. A bad stop bit (or bad
// parity) sets the sticky frame_err and drops the byte; a good frame that
// finds the FIFO full with no pop in the same cycle sets the sticky overrun
// and drops the byte.
//
// Ports:
//   clk        single clock, rising edge
//   clr        synchronous active-high reset, highest priority
//   bus        serial_in_port_if.slave (sin, sin_stb, ack, data_out, valid,
//              full, frame_err, overrun)
//   state_dbg  current receiver FSM state (IDLE=0, DATA=1, PAR=2, STOP=3)
//
// Parameter DEPTH: FIFO depth in bytes, power of two, 2..16.
// Build option: define SERIAL_IN_PARITY_EN to add the PAR state and require
// odd parity over the 8 data bits plus the parity bit.
module serial_in_port #(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              clr,
  serial_in_port_if.slave   bus,
  output logic [1:0]        state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

`ifdef SERIAL_IN_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2, STOP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd3} state_t;
`endif

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bad;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          frame_err_q;
  logic          overrun_q;

  logic stop_stb;
  logic good_frame;
  logic is_full;
  logic pop;
  logic push;

  // A pop frees a slot in the same edge, so a push into a full FIFO still
  // succeeds when ack is present.
  assign stop_stb   = bus.sin_stb && (state == STOP);
  assign good_frame = stop_stb && bus.sin && !par_bad;
  assign is_full    = (count == FULL_CNT);
  assign pop        = bus.ack && (count != '0);
  assign push       = good_frame && (!is_full || pop);

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      par_bad     <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (bus.sin_stb) begin
        case (state)
          IDLE: begin
            // A 1 while idle is line noise / idle level, not an error.
            if (!bus.sin) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
              par_bad <= 1'b0;
            end
          end
          DATA: begin
            shreg[bit_cnt] <= bus.sin;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef SERIAL_IN_PARITY_EN
              state <= PAR;
`else
              state <= STOP;
`endif
            end
          end
`ifdef SERIAL_IN_PARITY_EN
          PAR: begin
            // Odd parity: data bits plus parity bit must hold an odd number of ones.
            par_bad <= ~(^{shreg, bus.sin});
            state   <= STOP;
          end
`endif
          STOP: begin
            state <= IDLE;
            if (!(bus.sin && !par_bad)) frame_err_q <= 1'b1;
            else if (is_full && !pop)   overrun_q   <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end

      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // After a pop that empties the FIFO, data_out keeps showing a stale slot
  // with valid=0; the downstream register only loads on valid.
  assign bus.data_out  = mem[rd_ptr];
  assign bus.valid     = (count != '0);
  assign bus.full      = is_full;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign state_dbg     = state;

endmodule

// File: doc/serial_in_port.md
SERIAL_IN_PORT -- requirements
Module: serial_in_port

Interface
REQ-001 Parameter DEPTH, default 2, byte FIFO depth; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 sin  input  1  serial data line, sampled only when sin_stb=1.
REQ-005 sin_stb  input  1  one-cycle bit strobe; one serial bit per strobe.
REQ-006 ack  input  1  consumer pop request, from the data-input register load.
REQ-007 data_out  output  8  FIFO head byte; feeds the data-input register In port.
REQ-008 valid  output  1  FIFO not empty.
REQ-009 full  output  1  FIFO holds DEPTH bytes.
REQ-010 frame_err  output  1  sticky; bad stop bit, or bad parity when enabled.
REQ-011 overrun  output  1  sticky; good frame completed while FIFO full.

Function
REQ-012 Frame SHALL be: start bit 0, 8 data bits LSB first, optional parity bit (REQ-026), stop bit 1; one bit per sin_stb.
REQ-013 FSM states SHALL be IDLE, DATA, PAR, STOP; cycles with sin_stb=0 SHALL not change state or counters.
REQ-014 IDLE: sin_stb with sin=0 -> DATA with bit count 0; sin_stb with sin=1 -> stay IDLE, no flag.
REQ-015 DATA: each sin_stb shifts sin into bit [count]; the 8th strobe -> PAR if enabled, else STOP.
REQ-016 STOP: sin_stb with sin=1 and no parity error -> push byte, IDLE; otherwise -> set frame_err, discard byte, IDLE.
REQ-017 Push SHALL occur at the clock edge that samples the stop bit; valid SHALL rise at that same edge when FIFO was empty.
REQ-018 Push when full with no pop that cycle SHALL discard the new byte, set overrun, and leave FIFO contents unchanged.
REQ-019 ack while valid=1 SHALL pop the head at that edge; data_out SHALL show the next byte (or hold stale data with valid=0) the following cycle.
REQ-020 ack while valid=0 SHALL be ignored.
REQ-021 Simultaneous push and pop SHALL both succeed, including when full; count unchanged, no overrun.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-023 data_out SHALL be driven continuously (not tri-stated); bus gating stays in the downstream register.

Reset
REQ-024 clr=1 at a clock edge SHALL force state IDLE, bit count 0, shift register 0, FIFO pointers and count 0, data_out 8'h00, valid 0, full 0, frame_err 0, overrun 0.
REQ-025 clr SHALL take priority over sin_stb and ack in the same cycle; a frame in progress SHALL be abandoned without pushing or flagging.

Configuration
REQ-026 With macro SERIAL_IN_PARITY_EN defined: PAR state present; parity bit sampled after bit 7; odd parity over 8 data bits + parity bit required; a mismatch marks the frame bad and REQ-016 sets frame_err at STOP.
REQ-027 Without SERIAL_IN_PARITY_EN: no PAR state; DATA goes directly to STOP; frame is 10 bits.

Verification
REQ-028 clr 1 cycle, then frame for 8'hA5 (bits 0,1,0,1,0,0,1,0,1,1) -> valid=1, data_out=8'hA5 after the stop-bit edge; ack 1 cycle -> valid=0.
REQ-029 Frames 8'h03, 8'h06, 8'h09 with no ack, DEPTH=2 -> full=1 after 8'h06, overrun=1 after 8'h09; pops return 8'h03 then 8'h06.
REQ-030 Frame 8'h3C with stop bit 0 -> frame_err=1, valid stays 0; next good frame 8'h11 -> valid=1, data_out=8'h11, frame_err still 1.
REQ-031 FIFO full, ack asserted on the same cycle as stop bit of 8'h7E -> overrun=0, full stays 1, head advances, 8'h7E stored at tail.
REQ-032 clr asserted after 4 data bits of a frame -> all outputs zero next cycle; fresh frame 8'h55 received correctly.
REQ-033 With SERIAL_IN_PARITY_EN: 8'h01 with parity bit 0 -> pushed; same byte with parity bit 1 -> frame_err=1, not pushed.
